// File: rtl/isa_types.sv
// Shared ISA-level widths and the memory-port payload used by the hart and its arbiter.
package isa_types;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned MEM_READ_LATENCY = 1;

    typedef enum logic [1:0] {
        write_byte,
        write_half,
        write_word
    } mem_width_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wenable;
        mem_width_t      wwidth;
        logic [XLEN-1:0] wdata;
    } mem_control_t;

    typedef enum logic {
        grant_fetch,
        grant_data
    } mem_requester_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single memory port between instruction fetch and load/store.
// One access per two cycles: accept in IDLE, hold the address and return data in BUSY.
module mem_arbiter
    import isa_types::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_req_valid,
    input  logic [XLEN-1:0]    fetch_req_addr,
    output logic               fetch_req_ready,
    output logic               fetch_resp_valid,
    output logic [XLEN-1:0]    fetch_resp_data,
    input  logic               data_req_valid,
    input  mem_control_t       data_req_ctrl,
    output logic               data_req_ready,
    output logic               data_resp_valid,
    output logic [XLEN-1:0]    data_resp_data,
    output mem_control_t       mem_ctrl,
    input  logic [XLEN-1:0]    mem_rdata
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam mem_control_t IDLE_CTRL = '{
        addr:    '0,
        wenable: 1'b0,
        wwidth:  write_word,
        wdata:   '0
    };

    state_t         state;
    mem_requester_t owner;
    mem_requester_t last_grant;
    mem_control_t   held_ctrl;
    logic           held_write;

    logic           grant_valid;
    mem_requester_t grant;
    mem_control_t   fetch_ctrl;
    mem_control_t   win_ctrl;
    logic           busy_resp;

    if (MEM_READ_LATENCY != 1) begin : g_latency_check
        $error("mem_arbiter supports a single-cycle memory read only");
    end

    // Round-robin pick: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant       = grant_fetch;
        grant_valid = (state == IDLE) && (fetch_req_valid || data_req_valid);
        if (fetch_req_valid && data_req_valid) begin
            grant = (last_grant == grant_fetch) ? grant_data : grant_fetch;
        end else if (data_req_valid) begin
            grant = grant_data;
        end
    end

    always_comb begin
        fetch_ctrl      = IDLE_CTRL;
        fetch_ctrl.addr = fetch_req_addr;
        win_ctrl        = (grant == grant_data) ? data_req_ctrl : fetch_ctrl;
    end

    always_comb begin
        fetch_req_ready = !reset && grant_valid && (grant == grant_fetch);
        data_req_ready  = !reset && grant_valid && (grant == grant_data);

        if (reset) begin
            mem_ctrl = IDLE_CTRL;
        end else if (state == BUSY) begin
            mem_ctrl = held_ctrl;
        end else if (grant_valid) begin
            mem_ctrl = win_ctrl;
        end else begin
            mem_ctrl = IDLE_CTRL;
        end
    end

    // Response leaves during BUSY; a reset in that cycle drops it.
    always_comb begin
        busy_resp        = !reset && (state == BUSY);
        fetch_resp_valid = busy_resp && (owner == grant_fetch);
        data_resp_valid  = busy_resp && (owner == grant_data);
        fetch_resp_data  = fetch_resp_valid ? mem_rdata : '0;
        data_resp_data   = (data_resp_valid && !held_write) ? mem_rdata : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= grant_fetch;
            last_grant <= grant_data;
            held_ctrl  <= '0;
            held_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state      <= BUSY;
                        owner      <= grant;
                        last_grant <= grant;
                        held_ctrl  <= '{
                            addr:    win_ctrl.addr,
                            wenable: 1'b0,
                            wwidth:  win_ctrl.wwidth,
                            wdata:   win_ctrl.wdata
                        };
                        held_write <= win_ctrl.wenable;
                    end
                end
                BUSY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory model and a response scoreboard.
module tb_mem_arbiter;
    import isa_types::*;

    typedef struct packed {
        logic        is_data;
        logic [31:0] data;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            fetch_req_valid;
    logic [XLEN-1:0] fetch_req_addr;
    logic            fetch_req_ready;
    logic            fetch_resp_valid;
    logic [XLEN-1:0] fetch_resp_data;
    logic            data_req_valid;
    mem_control_t    data_req_ctrl;
    logic            data_req_ready;
    logic            data_resp_valid;
    logic [XLEN-1:0] data_resp_data;
    mem_control_t    mem_ctrl;
    logic [XLEN-1:0] mem_rdata;

    logic [7:0]      mem [0:8191];
    logic [31:0]     rdata_q;
    int              write_count = 0;
    int              cyc = 0;
    int              errors = 0;
    int              checks = 0;

    exp_t            sb[$];
    exp_t            e;
    int              grant_log[$];
    int              acc_cyc[$];
    mem_control_t    acc_ctrl;

    mem_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_addr   (fetch_req_addr),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_data  (fetch_resp_data),
        .data_req_valid   (data_req_valid),
        .data_req_ctrl    (data_req_ctrl),
        .data_req_ready   (data_req_ready),
        .data_resp_valid  (data_resp_valid),
        .data_resp_data   (data_resp_data),
        .mem_ctrl         (mem_ctrl),
        .mem_rdata        (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] read_word(input logic [31:0] a);
        int unsigned b;
        b = 32'({a[12:2], 2'b00});
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Memory model: synchronous RAM/ROM, combinational input peripheral at 0x1000..0x17FF.
    always @(posedge clock) begin
        int unsigned a;
        cyc <= cyc + 1;
        rdata_q <= read_word(mem_ctrl.addr);
        a = 32'(mem_ctrl.addr[12:0]);
        if (mem_ctrl.wenable) begin
            write_count = write_count + 1;
            case (mem_ctrl.wwidth)
                write_byte: mem[a] = mem_ctrl.wdata[7:0];
                write_half: begin
                    mem[a]   = mem_ctrl.wdata[7:0];
                    mem[a+1] = mem_ctrl.wdata[15:8];
                end
                default: begin
                    a = a & 32'hFFFF_FFFC;
                    mem[a]   = mem_ctrl.wdata[7:0];
                    mem[a+1] = mem_ctrl.wdata[15:8];
                    mem[a+2] = mem_ctrl.wdata[23:16];
                    mem[a+3] = mem_ctrl.wdata[31:24];
                end
            endcase
        end
    end

    always @* begin
        if (mem_ctrl.addr[31:11] == 21'h2) mem_rdata = read_word(mem_ctrl.addr);
        else                               mem_rdata = rdata_q;
    end

    // Scoreboard: push at accept, pop and compare on each response strobe.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (fetch_resp_valid || data_resp_valid) begin
                chk("resp_overlap", 32'(fetch_resp_valid && data_resp_valid), 0);
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 32'(fetch_resp_valid || data_resp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", 32'(data_resp_valid), 32'(e.is_data));
                    chk("resp_data", data_resp_valid ? data_resp_data : fetch_resp_data, e.data);
                end
            end
            if (fetch_req_ready) begin
                sb.push_back('{is_data: 1'b0, data: read_word(fetch_req_addr)});
                grant_log.push_back(0);
                acc_cyc.push_back(cyc);
            end
            if (data_req_ready) begin
                sb.push_back('{is_data: 1'b1,
                               data: data_req_ctrl.wenable ? 32'h0 : read_word(data_req_ctrl.addr)});
                grant_log.push_back(1);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic issue_fetch(input logic [31:0] addr);
        logic got = 1'b0;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = addr;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (fetch_req_ready) begin
                got      = 1'b1;
                acc_ctrl = mem_ctrl;
            end else begin
                @(posedge clock); #1;
            end
        end
        chk("fetch_accept", 32'(got), 1);
        @(posedge clock); #1;
        fetch_req_valid = 1'b0;
    endtask

    task automatic issue_data(input mem_control_t ctrl);
        logic got = 1'b0;
        data_req_valid = 1'b1;
        data_req_ctrl  = ctrl;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (data_req_ready) begin
                got      = 1'b1;
                acc_ctrl = mem_ctrl;
            end else begin
                @(posedge clock); #1;
            end
        end
        chk("data_accept", 32'(got), 1);
        @(posedge clock); #1;
        data_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int wc0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        {mem[7], mem[6], mem[5], mem[4]}             = 32'hDEADBEEF;
        {mem[11], mem[10], mem[9], mem[8]}           = 32'hCAFEF00D;
        {mem[4099], mem[4098], mem[4097], mem[4096]} = 32'h44332211;
        mem[6145] = 8'h5A;

        // Reset with both requesters already valid: nothing may leak out.
        reset           = 1'b1;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = 32'h4;
        data_req_valid  = 1'b1;
        data_req_ctrl   = '{addr: 32'h8, wenable: 1'b0, wwidth: write_word, wdata: 32'h0};
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_fetch_ready", 32'(fetch_req_ready), 0);
        chk("rst_data_ready", 32'(data_req_ready), 0);
        chk("rst_fetch_resp", 32'(fetch_resp_valid), 0);
        chk("rst_data_resp", 32'(data_resp_valid), 0);
        chk("rst_wenable", 32'(mem_ctrl.wenable), 0);
        chk("rst_fetch_data", fetch_resp_data, 0);
        chk("rst_data_data", data_resp_data, 0);

        // Contention from reset: fetch, data, fetch, data, every other cycle.
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        fetch_req_valid = 1'b0;
        data_req_valid  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("cont_count", 32'(grant_log.size()), 4);
        if (grant_log.size() >= 4) begin
            chk("cont_g0", 32'(grant_log[0]), 0);
            chk("cont_g1", 32'(grant_log[1]), 1);
            chk("cont_g2", 32'(grant_log[2]), 0);
            chk("cont_g3", 32'(grant_log[3]), 1);
            chk("cont_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 2);
            chk("cont_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 2);
            chk("cont_gap3", 32'(acc_cyc[3] - acc_cyc[2]), 2);
        end
        chk("cont_drain", 32'(sb.size()), 0);

        // Fetch only.
        issue_fetch(32'h4);
        chk("f_acc_addr", acc_ctrl.addr, 32'h4);
        chk("f_acc_wen", 32'(acc_ctrl.wenable), 0);
        @(negedge clock);
        chk("f_busy_addr", mem_ctrl.addr, 32'h4);
        chk("f_resp_valid", 32'(fetch_resp_valid), 1);
        chk("f_resp_data", fetch_resp_data, 32'hDEADBEEF);
        @(posedge clock); #1;

        // Store word then load it back.
        issue_data('{addr: 32'h800, wenable: 1'b1, wwidth: write_word, wdata: 32'h12345678});
        chk("st_acc_wen", 32'(acc_ctrl.wenable), 1);
        @(negedge clock);
        chk("st_busy_wen", 32'(mem_ctrl.wenable), 0);
        chk("st_ack_valid", 32'(data_resp_valid), 1);
        chk("st_ack_data", data_resp_data, 0);
        @(posedge clock); #1;
        issue_data('{addr: 32'h800, wenable: 1'b0, wwidth: write_word, wdata: 32'h0});
        @(negedge clock);
        chk("ld_resp_valid", 32'(data_resp_valid), 1);
        chk("ld_resp_data", data_resp_data, 32'h12345678);
        @(posedge clock); #1;

        // Input peripheral read, address held through BUSY.
        issue_data('{addr: 32'h1000, wenable: 1'b0, wwidth: write_word, wdata: 32'h0});
        chk("pr_acc_addr", acc_ctrl.addr, 32'h1000);
        @(negedge clock);
        chk("pr_busy_addr", mem_ctrl.addr, 32'h1000);
        chk("pr_resp_data", data_resp_data, 32'h44332211);
        @(posedge clock); #1;

        // Reset during the BUSY cycle of a load drops the response.
        issue_data('{addr: 32'h800, wenable: 1'b0, wwidth: write_word, wdata: 32'h0});
        reset = 1'b1;
        @(negedge clock);
        chk("rm_no_resp", 32'(data_resp_valid), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rm_fetch_ready", 32'(fetch_req_ready), 0);
        chk("rm_data_ready", 32'(data_req_ready), 0);
        chk("rm_data_resp", 32'(data_resp_valid), 0);
        chk("rm_fetch_resp", 32'(fetch_resp_valid), 0);
        chk("rm_wenable", 32'(mem_ctrl.wenable), 0);
        chk("rm_addr", mem_ctrl.addr, 0);
        chk("rm_data", data_resp_data, 0);
        @(posedge clock); #1;
        issue_data('{addr: 32'h800, wenable: 1'b0, wwidth: write_word, wdata: 32'h0});
        @(negedge clock);
        chk("rm_reissue_valid", 32'(data_resp_valid), 1);
        chk("rm_reissue_data", data_resp_data, 32'h12345678);
        @(posedge clock); #1;

        // Output peripheral byte store: one write, neighbouring byte untouched.
        wc0 = write_count;
        issue_data('{addr: 32'h1800, wenable: 1'b1, wwidth: write_byte, wdata: 32'h000000A5});
        @(negedge clock);
        chk("pb_busy_wen", 32'(mem_ctrl.wenable), 0);
        chk("pb_byte0", 32'(mem[6144]), 32'hA5);
        chk("pb_byte1", 32'(mem[6145]), 32'h5A);
        chk("pb_ack_data", data_resp_data, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("pb_write_count", 32'(write_count - wc0), 1);

        chk("final_drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
